// File: rtl/mm_stream_sequencer.sv
// Stream front/back end for the 2x2 matrix-multiply controller: turns 8 operand bytes
// into load strobes, waits for a fresh done edge, then reads and streams out C0..C3.
module mm_stream_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              load_en,
    output logic              load_sel_ab,
    output logic [1:0]        load_index,
    output logic [DATA_W-1:0] load_data,
    input  logic              mm_done,
    output logic              output_en,
    output logic [1:0]        output_sel,
    input  logic [DATA_W-1:0] result_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {S_LOAD, S_WAIT, S_FETCH, S_SEND, S_ERR} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [2:0]        ld_cnt_q, ld_cnt_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            ld_cnt_q    <= '0;
            rd_idx_q    <= '0;
            wait_cnt_q  <= '0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            rd_idx_q    <= rd_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        rd_idx_d    = rd_idx_q;
        wait_cnt_d  = wait_cnt_q;
        done_d      = mm_done;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        load_en     = 1'b0;
        output_en   = 1'b0;
        output_sel  = '0;

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                // Gated by rst_n so an async reset kills the strobe in the same cycle.
                load_en  = in_valid & rst_n;
                if (in_valid) begin
                    ld_cnt_d = ld_cnt_q + 3'd1;
                    if (ld_cnt_q == 3'd7) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done edge on the final timeout cycle still wins over the error.
                if (mm_done && !done_q) begin
                    state_d    = S_FETCH;
                    rd_idx_d   = '0;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_FETCH: begin
                output_en   = 1'b1;
                output_sel  = rd_idx_q;
                out_data_d  = result_data;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd_idx_q == 2'd3) begin
                        rd_idx_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 2'd1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_ERR: state_d = S_ERR;
            default: state_d = S_LOAD;
        endcase
    end

    assign load_sel_ab = ld_cnt_q[2];
    assign load_index  = ld_cnt_q[1:0];
    assign load_data   = load_en ? in_data : '0;
    assign busy        = !((state_q == S_LOAD) && (ld_cnt_q == 3'd0));
    assign err         = err_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_mm_stream_sequencer.sv
// Self-checking bench for mm_stream_sequencer: a behavioural controller stores the
// written operands and answers reads with the 2x2 product (or fixed 10+sel values).
module tb_mm_stream_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       load_en, load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] load_data;
    logic       mm_done;
    logic       output_en;
    logic [1:0] output_sel;
    logic [7:0] result_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       busy, err;

    int checks = 0;
    int passes = 0;
    bit fixed_mode = 1'b1;
    logic [7:0] ctrl_a [4];
    logic [7:0] ctrl_b [4];

    mm_stream_sequencer #(.DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .load_en(load_en), .load_sel_ab(load_sel_ab),
        .load_index(load_index), .load_data(load_data), .mm_done(mm_done),
        .output_en(output_en), .output_sel(output_sel), .result_data(result_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mm_c(input logic [7:0] a [4], input logic [7:0] b [4], input int idx);
        int i = idx / 2;
        int j = idx % 2;
        return 8'(a[i*2] * b[j] + a[i*2+1] * b[2+j]);
    endfunction

    // Behavioural controller: element storage written by the strobes, product on read.
    always @(posedge clk) begin
        if (load_en) begin
            if (load_sel_ab) ctrl_b[load_index] <= load_data;
            else             ctrl_a[load_index] <= load_data;
        end
    end

    always_comb begin
        result_data = 8'd0;
        if (fixed_mode) result_data = 8'(10 + output_sel);
        else            result_data = mm_c(ctrl_a, ctrl_b, int'(output_sel));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_bytes(input logic [7:0] b [8], input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                #1;
                checks++; if (load_en !== 1'b0) $display("FAIL gap_load_en: got %b exp 0", load_en); else passes++;
                checks++; if (in_ready !== 1'b1) $display("FAIL gap_in_ready: got %b exp 1", in_ready); else passes++;
                tick();
            end
            in_valid = 1'b1;
            in_data  = b[i];
            #1;
            checks++; if (load_en !== 1'b1) $display("FAIL load_en[%0d]: got %b exp 1", i, load_en); else passes++;
            checks++; if ({load_sel_ab, load_index} !== 3'(i)) $display("FAIL load_addr[%0d]: got %0d exp %0d", i, {load_sel_ab, load_index}, i); else passes++;
            checks++; if (load_data !== b[i]) $display("FAIL load_data[%0d]: got %0h exp %0h", i, load_data, b[i]); else passes++;
            tick();
        end
        in_data = 8'hEE;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL in_ready_after_8: got %b exp 0", in_ready); else passes++;
        checks++; if (load_en !== 1'b0) $display("FAIL load_en_after_8: got %b exp 0", load_en); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL busy_wait: got %b exp 1", busy); else passes++;
        in_valid = 1'b0;
    endtask

    // Called in the FETCH cycle of result 0. mode 0: always ready, 1: stall result 1, 2: random.
    task automatic collect(input logic [7:0] exp [4], input int mode);
        int got = 0;
        int stall = 0;
        int hs [4];
        for (int c = 0; c < 200 && got < 4; c++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = !(got == 1 && stall < 6);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            checks++; if (output_en && out_valid) $display("FAIL excl_oe_ov: got 1 exp 0"); else passes++;
            checks++; if (load_en !== 1'b0) $display("FAIL load_en_in_read: got %b exp 0", load_en); else passes++;
            if (out_valid) begin
                checks++; if (out_data !== exp[got]) $display("FAIL out_data[%0d]: got %0d exp %0d", got, out_data, exp[got]); else passes++;
                if (!out_ready) begin
                    stall++;
                    checks++; if (output_en !== 1'b0) $display("FAIL stall_output_en: got %b exp 0", output_en); else passes++;
                end else begin
                    hs[got] = c;
                    got++;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (got !== 4) $display("FAIL result_count: got %0d exp 4", got); else passes++;
        if (mode == 0 && got == 4) begin
            for (int i = 1; i < 4; i++) begin
                checks++; if (hs[i] - hs[i-1] !== 2) $display("FAIL spacing[%0d]: got %0d exp 2", i, hs[i] - hs[i-1]); else passes++;
            end
        end
        if (mode == 1) begin
            checks++; if (stall !== 6) $display("FAIL stall_cycles: got %0d exp 6", stall); else passes++;
        end
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL busy_after_read: got %b exp 0", busy); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL in_ready_after_read: got %b exp 1", in_ready); else passes++;
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) tick();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", in_ready); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else passes++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else passes++;
        checks++; if (load_en !== 1'b0) $display("FAIL reset_load_en: got %b exp 0", load_en); else passes++;
        checks++; if (load_data !== 8'd0) $display("FAIL reset_load_data: got %0h exp 0", load_data); else passes++;
        checks++; if (output_en !== 1'b0) $display("FAIL reset_output_en: got %b exp 0", output_en); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else passes++;
        checks++; if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0h exp 0", out_data); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b exp 0", err); else passes++;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_stream();
        logic [7:0] b [8];
        logic [7:0] e [4];
        fixed_mode = 1'b1;
        for (int i = 0; i < 8; i++) b[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) e[i] = 8'(10 + i);
        load_bytes(b, 1'b0);
        pulse_done(5);
        collect(e, 0);
    endtask

    task automatic test_backpressure();
        logic [7:0] b [8];
        logic [7:0] e [4];
        fixed_mode = 1'b1;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) e[i] = 8'(10 + i);
        load_bytes(b, 1'b0);
        pulse_done(2);
        collect(e, 1);
    endtask

    task automatic test_timeout();
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        load_bytes(b, 1'b0);
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) tick();
            in_valid = 1'($urandom_range(0, 1));
            #1;
            checks++; if (err !== (n >= 16)) $display("FAIL timeout_err[%0d]: got %b exp %b", n, err, n >= 16); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL timeout_in_ready[%0d]: got %b exp 0", n, in_ready); else passes++;
            checks++; if (load_en !== 1'b0) $display("FAIL timeout_load_en[%0d]: got %b exp 0", n, load_en); else passes++;
        end
        in_valid = 1'b0;
        reset_pulse();
    endtask

    task automatic test_done_held();
        logic [7:0] b [8];
        logic [7:0] e [4];
        fixed_mode = 1'b0;
        mm_done = 1'b1;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        load_bytes(b, 1'b0);
        for (int n = 0; n < 16; n++) begin
            #1;
            checks++; if (output_en !== 1'b0) $display("FAIL held_no_fetch[%0d]: got %b exp 0", n, output_en); else passes++;
            tick();
        end
        checks++; if (err !== 1'b1) $display("FAIL held_err: got %b exp 1", err); else passes++;
        reset_pulse();
        mm_done = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) e[i] = mm_c(b[0:3], b[4:7], i);
        load_bytes(b, 1'b0);
        repeat (3) tick();
        mm_done = 1'b1;
        tick();
        checks++; if (output_en !== 1'b1) $display("FAIL reraise_fetch: got %b exp 1", output_en); else passes++;
        checks++; if (output_sel !== 2'd0) $display("FAIL reraise_sel: got %0d exp 0", output_sel); else passes++;
        collect(e, 2);
        mm_done = 1'b0;
    endtask

    task automatic test_reset_midload();
        logic [7:0] b [8];
        logic [7:0] e [4];
        fixed_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL midload_busy: got %b exp 1", busy); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (load_en !== 1'b0) $display("FAIL midload_rst_load_en: got %b exp 0", load_en); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midload_rst_busy: got %b exp 0", busy); else passes++;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) e[i] = mm_c(b[0:3], b[4:7], i);
        load_bytes(b, 1'b0);
        pulse_done(1);
        collect(e, 2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [8];
        logic [7:0] e [4];
        fixed_mode = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) e[i] = mm_c(b[0:3], b[4:7], i);
            load_bytes(b, 1'b1);
            pulse_done(int'($urandom_range(0, 10)));
            collect(e, 2);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        mm_done   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_timeout();
        test_done_held();
        test_reset_midload();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mm_stream_sequencer.md
Name: mm_stream_sequencer

Overview:
- Upstream/downstream glue for the 2x2 matrix-multiply controller.
- Accepts a valid/ready byte stream of 8 operands (A0..A3, then B0..B3) and converts it into the controller's load_en/load_sel_ab/load_index/in_data write strobes.
- Waits for the array's done, then reads C0..C3 through output_en/output_sel.
- Returns the four results as a valid/ready byte stream.

Parameters:
- DATA_W, 8: operand/result byte width.
- TIMEOUT_CYC, 255: maximum WAIT cycles before an error is flagged; 1..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand byte valid
- in_ready  out  1  sequencer can accept an operand
- in_data  in  DATA_W  operand byte
- load_en  out  1  controller write strobe
- load_sel_ab  out  1  0 = A matrix, 1 = B matrix
- load_index  out  2  element index 0..3
- load_data  out  DATA_W  byte to controller in_data
- mm_done  in  1  controller done, level
- output_en  out  1  controller result read enable
- output_sel  out  2  result index 0..3
- result_data  in  DATA_W  controller out_data, combinational from output_sel
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  registered result byte
- busy  out  1  high in every state except LOAD with ld_cnt==0
- err  out  1  sticky timeout flag

Behaviour:
- States: LOAD, WAIT, FETCH, SEND, ERR. rst_n low forces LOAD immediately, even mid-operation.
- Reset values: ld_cnt=0, rd_idx=0, wait_cnt=0, done_q=0, out_data=0, out_valid=0, err=0.
- All outputs are 0 during reset except in_ready, which reads 1 in LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, in the same cycle and combinationally: load_en=1, load_data=in_data, load_sel_ab=ld_cnt[2], load_index=ld_cnt[1:0]. ld_cnt increments at the edge.
  - in_valid with in_ready low is ignored; no write occurs.
  - Accepting the byte with ld_cnt==7 sets ld_cnt=0 and moves to WAIT.
- WAIT:
  - in_ready=0. wait_cnt increments every cycle.
  - done_q registers mm_done every cycle in all states. A rising edge (mm_done & !done_q) moves to FETCH with rd_idx=0 and wait_cnt=0.
  - A done level already high on WAIT entry does not count; a fresh rising edge is required.
  - wait_cnt==TIMEOUT_CYC-1 with no rising edge moves to ERR. A rising edge on that same cycle wins and the FSM goes to FETCH.
- FETCH:
  - output_en=1, output_sel=rd_idx for exactly one cycle.
  - out_data<=result_data and out_valid<=1 at the edge; go to SEND.
- SEND:
  - out_valid=1; out_data is held stable until out_valid&out_ready.
  - On the handshake, out_valid<=0. If rd_idx==3: rd_idx<=0 and go to LOAD. Otherwise rd_idx++ and go to FETCH.
  - Throughput: 2 cycles per result minimum.
- ERR: err=1, in_ready=0, out_valid=0. The block stays here until rst_n is asserted.
- load_en, output_en and out_valid are never high simultaneously.
- Outside LOAD, load_en=0. Outside FETCH, output_en=0.

Test Plan:
- Stream bytes 1,2,3,4,5,6,7,8 with in_valid held high -> 8 consecutive load_en cycles with (sel,idx) = (0,0)..(0,3),(1,0)..(1,3) and load_data 1..8; in_ready drops the cycle after byte 8.
- Pulse mm_done 5 cycles after the loads, model result_data = 10+output_sel, out_ready=1 -> out_data 10,11,12,13, each out_valid for 1 cycle spaced 2 cycles apart; FSM then back in LOAD with busy=0.
- Hold out_ready low 6 cycles during result 1 -> out_valid and out_data=11 stable throughout; no further output_en until the handshake.
- Never raise mm_done (TIMEOUT_CYC=16) -> err=1 exactly 16 cycles after WAIT entry; in_ready stays 0; a 1-cycle rst_n pulse clears err and in_ready returns to 1 asynchronously.
- Hold mm_done high from before WAIT entry -> no FETCH; timeout and err=1. Drop then re-raise mm_done on the next run -> FETCH occurs.
- Assert rst_n low after 3 operands are loaded -> load_en=0 at once; the next 8 bytes restart at (0,0).
